// File: rtl/lcd_cmd_receiver.sv
// Serial LCD command receiver: decodes a 3/4-wire SPI-like panel bus into bytes,
// panel state flags, window registers and RGB565 pixel writes.
module lcd_cmd_receiver #(
  parameter logic [15:0] DEF_XE = 16'd134,
  parameter logic [15:0] DEF_YE = 16'd239
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_rst,
  input  logic        lcd_cs,
  input  logic        lcd_scl,
  input  logic        lcd_sd,
  input  logic        lcd_rs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        sleep,
  output logic        disp_on,
  output logic        inv_on,
  output logic        unk_cmd
);

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_INVOFF  = 8'h20;
  localparam logic [7:0] OP_INVON   = 8'h21;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  // Bit order {lcd_rst, rs, sd, scl, cs}; idle values keep cs and panel reset deasserted.
  localparam logic [4:0] SYNC_RST = 5'b10001;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [2:0]  arg_cnt;
    logic [23:0] args;
    logic        phase;
    logic [7:0]  hi;
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
    logic [15:0] x;
    logic [15:0] y;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_data;
    logic        sleep;
    logic        disp_on;
    logic        inv_on;
    logic        unk_cmd;
  } dec_t;

  localparam dec_t DEC_RST = '{
    opcode: OP_NOP, arg_cnt: 3'd0, args: 24'd0, phase: 1'b0, hi: 8'd0,
    xs: 16'd0, xe: DEF_XE, ys: 16'd0, ye: DEF_YE, x: 16'd0, y: 16'd0,
    pix_valid: 1'b0, pix_x: 16'd0, pix_y: 16'd0, pix_data: 16'd0,
    sleep: 1'b1, disp_on: 1'b0, inv_on: 1'b0, unk_cmd: 1'b0
  };

  logic [4:0] sync1_q, sync2_q;
  logic       scl_prev_q;
  logic       cs_s, scl_s, sd_s, rs_s, prst_n_s, scl_rise;

  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_dc_q, byte_dc_d;
  logic [7:0] byte_data_q, byte_data_d;
  dec_t       dec_q, dec_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      scl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {lcd_rst, lcd_rs, lcd_sd, lcd_scl, lcd_cs};
      sync2_q    <= sync1_q;
      scl_prev_q <= scl_s;
    end
  end

  assign cs_s     = sync2_q[0];
  assign scl_s    = sync2_q[1];
  assign sd_s     = sync2_q[2];
  assign rs_s     = sync2_q[3];
  assign prst_n_s = sync2_q[4];
  assign scl_rise = scl_s & ~scl_prev_q & ~cs_s;

  // Byte assembly: a deselect throws away any partial byte.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    if (!prst_n_s) begin
      shift_d     = 7'd0;
      bit_cnt_d   = 3'd0;
      byte_data_d = 8'd0;
      byte_dc_d   = 1'b0;
    end else if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (scl_rise) begin
      shift_d   = {shift_q[5:0], sd_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q, sd_s};
        byte_dc_d    = rs_s;
      end
    end
  end

  always_comb begin
    dec_d           = dec_q;
    dec_d.pix_valid = 1'b0;
    dec_d.unk_cmd   = 1'b0;
    if (!prst_n_s) begin
      dec_d = DEC_RST;
    end else if (byte_valid_q && !byte_dc_q) begin
      dec_d.opcode  = byte_data_q;
      dec_d.arg_cnt = 3'd0;
      dec_d.phase   = 1'b0;
      case (byte_data_q)
        OP_SWRESET: dec_d = DEC_RST;
        OP_SLPIN:   dec_d.sleep = 1'b1;
        OP_SLPOUT:  dec_d.sleep = 1'b0;
        OP_INVOFF:  dec_d.inv_on = 1'b0;
        OP_INVON:   dec_d.inv_on = 1'b1;
        OP_DISPOFF: dec_d.disp_on = 1'b0;
        OP_DISPON:  dec_d.disp_on = 1'b1;
        OP_RAMWR: begin
          dec_d.x = dec_q.xs;
          dec_d.y = dec_q.ys;
        end
        OP_NOP, OP_CASET, OP_RASET: ;
        default:    dec_d.unk_cmd = 1'b1;
      endcase
    end else if (byte_valid_q) begin
      case (dec_q.opcode)
        // Window only commits on the 4th argument; later arguments are dropped.
        OP_CASET, OP_RASET: begin
          if (dec_q.arg_cnt != 3'd4) begin
            dec_d.arg_cnt = dec_q.arg_cnt + 3'd1;
            dec_d.args    = {dec_q.args[15:0], byte_data_q};
            if (dec_q.arg_cnt == 3'd3) begin
              if (dec_q.opcode == OP_CASET) {dec_d.xs, dec_d.xe} = {dec_q.args, byte_data_q};
              else                          {dec_d.ys, dec_d.ye} = {dec_q.args, byte_data_q};
            end
          end
        end
        OP_RAMWR: begin
          if (!dec_q.phase) begin
            dec_d.hi    = byte_data_q;
            dec_d.phase = 1'b1;
          end else begin
            dec_d.phase     = 1'b0;
            dec_d.pix_valid = 1'b1;
            dec_d.pix_x     = dec_q.x;
            dec_d.pix_y     = dec_q.y;
            dec_d.pix_data  = {dec_q.hi, byte_data_q};
            // Only equality is compared, so a start above the end wraps through 0xFFFF.
            if (dec_q.x == dec_q.xe) begin
              dec_d.x = dec_q.xs;
              dec_d.y = (dec_q.y == dec_q.ye) ? dec_q.ys : dec_q.y + 16'd1;
            end else begin
              dec_d.x = dec_q.x + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q      <= 7'd0;
      bit_cnt_q    <= 3'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_dc_q    <= 1'b0;
      dec_q        <= DEC_RST;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      dec_q        <= dec_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign pix_valid  = dec_q.pix_valid;
  assign pix_x      = dec_q.pix_x;
  assign pix_y      = dec_q.pix_y;
  assign pix_data   = dec_q.pix_data;
  assign sleep      = dec_q.sleep;
  assign disp_on    = dec_q.disp_on;
  assign inv_on     = dec_q.inv_on;
  assign unk_cmd    = dec_q.unk_cmd;

endmodule

// File: tb/tb_lcd_cmd_receiver.sv
// Self-checking bench for lcd_cmd_receiver: drives the serial panel bus and compares
// bytes, flags and pixel writes against a command-level reference model.
module tb_lcd_cmd_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lcdRst = 1'b1;
  logic        lcdCs = 1'b1;
  logic        lcdScl = 1'b0;
  logic        lcdSd = 1'b0;
  logic        lcdRs = 1'b0;
  logic        byteValid, byteDc, pixValid, sleepFlag, dispOn, invOn, unkCmd;
  logic [7:0]  byteData;
  logic [15:0] pixX, pixY, pixData;

  lcd_cmd_receiver #(.DEF_XE(16'd134), .DEF_YE(16'd239)) dut (
    .clk(clk), .rst(rst), .lcd_rst(lcdRst), .lcd_cs(lcdCs), .lcd_scl(lcdScl),
    .lcd_sd(lcdSd), .lcd_rs(lcdRs), .byte_valid(byteValid), .byte_data(byteData),
    .byte_dc(byteDc), .pix_valid(pixValid), .pix_x(pixX), .pix_y(pixY),
    .pix_data(pixData), .sleep(sleepFlag), .disp_on(dispOn), .inv_on(invOn),
    .unk_cmd(unkCmd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
  } pix_t;

  pix_t       obsPix[$];
  pix_t       expPix[$];
  int         byteCycles = 0;
  int         unkCycles = 0;
  logic [7:0] lastByte = 8'd0;
  logic       lastDc = 1'b0;

  int checkCount = 0;
  int passCount = 0;
  int bytesSent = 0;
  int expUnk = 0;
  int pixChecked = 0;

  // Reference model state, kept at command level.
  logic [7:0]  mOp;
  logic [7:0]  mArgs[$];
  logic [15:0] mXs, mXe, mYs, mYe, mX, mY;
  logic        mPhase, mSleep, mDisp, mInv;
  logic [7:0]  mHi;

  always @(negedge clk) begin
    if (rst) begin
      if (byteValid) begin
        byteCycles++;
        lastByte = byteData;
        lastDc = byteDc;
      end
      if (pixValid) obsPix.push_back('{x: pixX, y: pixY, d: pixData});
      if (unkCmd) unkCycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOp = 8'h00; mArgs.delete(); mPhase = 1'b0; mHi = 8'h00;
    mXs = 16'd0; mXe = 16'd134; mYs = 16'd0; mYe = 16'd239; mX = 16'd0; mY = 16'd0;
    mSleep = 1'b1; mDisp = 1'b0; mInv = 1'b0;
  endtask

  task automatic modelByte(input logic dc, input logic [7:0] b);
    if (!dc) begin
      mOp = b; mArgs.delete(); mPhase = 1'b0;
      case (b)
        8'h01: modelReset();
        8'h10: mSleep = 1'b1;
        8'h11: mSleep = 1'b0;
        8'h20: mInv = 1'b0;
        8'h21: mInv = 1'b1;
        8'h28: mDisp = 1'b0;
        8'h29: mDisp = 1'b1;
        8'h2C: begin mX = mXs; mY = mYs; end
        8'h00, 8'h2A, 8'h2B: ;
        default: expUnk++;
      endcase
    end else if ((mOp == 8'h2A || mOp == 8'h2B) && mArgs.size() < 4) begin
      mArgs.push_back(b);
      if (mArgs.size() == 4) begin
        if (mOp == 8'h2A) begin mXs = {mArgs[0], mArgs[1]}; mXe = {mArgs[2], mArgs[3]}; end
        else              begin mYs = {mArgs[0], mArgs[1]}; mYe = {mArgs[2], mArgs[3]}; end
      end
    end else if (mOp == 8'h2C) begin
      if (!mPhase) begin
        mHi = b; mPhase = 1'b1;
      end else begin
        expPix.push_back('{x: mX, y: mY, d: {mHi, b}});
        mPhase = 1'b0;
        if (mX == mXe) begin
          mX = mXs;
          mY = (mY == mYe) ? mYs : mY + 16'd1;
        end else begin
          mX = mX + 16'd1;
        end
      end
    end
  endtask

  task automatic clockBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      lcdSd = b[i];
      #30 lcdScl = 1'b1;
      #30 lcdScl = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic dc, input logic [7:0] b);
    lcdRs = dc;
    clockBits(b, 8);
    #60;
    modelByte(dc, b);
    bytesSent++;
  endtask

  task automatic sendPixel(input logic [15:0] p);
    applyStimulus(1'b1, p[15:8]);
    applyStimulus(1'b1, p[7:0]);
  endtask

  task automatic sendWindow(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
    applyStimulus(1'b0, op);
    applyStimulus(1'b1, s[15:8]);
    applyStimulus(1'b1, s[7:0]);
    applyStimulus(1'b1, e[15:8]);
    applyStimulus(1'b1, e[7:0]);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".sleep"}, 32'(sleepFlag), 32'(mSleep));
    checkOutput({tag, ".disp"}, 32'(dispOn), 32'(mDisp));
    checkOutput({tag, ".inv"}, 32'(invOn), 32'(mInv));
    checkOutput({tag, ".bytes"}, byteCycles, bytesSent);
    checkOutput({tag, ".unk"}, unkCycles, expUnk);
    checkOutput({tag, ".pixCount"}, obsPix.size(), expPix.size());
    for (int i = pixChecked; i < expPix.size() && i < obsPix.size(); i++) begin
      checkOutput({tag, ".pixXY"}, {obsPix[i].x, obsPix[i].y}, {expPix[i].x, expPix[i].y});
      checkOutput({tag, ".pixData"}, 32'(obsPix[i].d), 32'(expPix[i].d));
    end
    pixChecked = expPix.size();
  endtask

  function automatic logic [31:0] obsXY(input int idx);
    return (obsPix.size() > idx) ? {obsPix[idx].x, obsPix[idx].y} : 32'hDEAD_BEEF;
  endfunction

  logic [7:0]  flagOps[6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h28, 8'h29};
  logic [31:0] ramwrXY[5] = '{{16'd2, 16'd5}, {16'd3, 16'd5}, {16'd2, 16'd6}, {16'd3, 16'd6}, {16'd2, 16'd5}};

  initial begin
    int base;
    logic [15:0] s, e;
    modelReset();
    #2;
    @(negedge clk);
    #40;
    checkOutput("rst.byteValid", 32'(byteValid), 32'd0);
    checkOutput("rst.byteData", 32'(byteData), 32'd0);
    checkOutput("rst.pixValid", 32'(pixValid), 32'd0);
    checkOutput("rst.pixXY", {pixX, pixY}, 32'd0);
    checkOutput("rst.pixData", 32'(pixData), 32'd0);
    checkOutput("rst.unk", 32'(unkCmd), 32'd0);
    checkState("rst");
    rst = 1'b1;
    #40 lcdCs = 1'b0;
    #40;

    // Byte in flight during reset is lost.
    clockBits(8'hFF, 4);
    rst = 1'b0;
    #30 rst = 1'b1;
    #40;
    modelReset();
    applyStimulus(1'b0, 8'h11);
    checkOutput("sleepOut.data", 32'(lastByte), 32'h11);
    checkOutput("sleepOut.dc", 32'(lastDc), 32'd0);
    checkState("sleepOut");
    applyStimulus(1'b0, 8'h29);
    checkState("dispOn");

    sendWindow(8'h2A, 16'd2, 16'd3);
    sendWindow(8'h2B, 16'd5, 16'd6);
    applyStimulus(1'b0, 8'h2C);
    base = obsPix.size();
    for (int i = 0; i < 5; i++) sendPixel(16'hF800 + 16'(i));
    for (int i = 0; i < 5; i++) checkOutput("ramwr.fixedXY", obsXY(base + i), ramwrXY[i]);
    checkState("ramwr");

    clockBits(8'hA5, 3);
    lcdCs = 1'b1;
    #60 lcdCs = 1'b0;
    #40;
    applyStimulus(1'b0, 8'h21);
    checkOutput("csAbort.data", 32'(lastByte), 32'h21);
    checkState("csAbort");

    applyStimulus(1'b0, 8'h55);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
    checkState("unknown");

    for (int iter = 0; iter < 6; iter++) begin
      applyStimulus(1'b0, flagOps[$urandom_range(0, 5)]);
      applyStimulus(1'b0, flagOps[$urandom_range(0, 5)]);
      s = (iter % 2 == 0) ? 16'($urandom_range(65532, 65535)) : 16'($urandom_range(0, 500));
      e = s + 16'($urandom_range(0, 3));
      sendWindow(8'h2A, s, e);
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
      s = 16'($urandom_range(0, 65535));
      e = s + 16'($urandom_range(0, 2));
      sendWindow(8'h2B, s, e);
      applyStimulus(1'b0, 8'h2C);
      for (int p = $urandom_range(3, 10); p > 0; p--) sendPixel(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        applyStimulus(1'b0, 8'h2C);
        sendPixel(16'($urandom_range(0, 65535)));
      end
      checkState("random");
    end

    applyStimulus(1'b0, 8'h21);
    applyStimulus(1'b0, 8'h29);
    applyStimulus(1'b0, 8'h01);
    checkState("swreset");
    applyStimulus(1'b0, 8'h2C);
    sendPixel(16'h1234);
    checkState("swresetPix");

    sendWindow(8'h2A, 16'd7, 16'd9);
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h2C);
    applyStimulus(1'b1, 8'hAB);
    lcdRst = 1'b0;
    #100 lcdRst = 1'b1;
    #40;
    modelReset();
    applyStimulus(1'b1, 8'hCD);
    applyStimulus(1'b1, 8'hEF);
    checkState("panelRst");

    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h05);
    applyStimulus(1'b0, 8'h2C);
    base = obsPix.size();
    for (int i = 0; i < 136; i++) sendPixel(16'(i));
    checkOutput("wrap.lastOfRow", obsXY(base + 134), {16'd134, 16'd0});
    checkOutput("wrap.nextRow", obsXY(base + 135), {16'd0, 16'd1});
    checkState("wrap");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_receiver.md
LCD_CMD_RECEIVER -- requirements
Module: lcd_cmd_receiver

Interface
REQ-001 SHALL have parameter DEF_XE, default 16'd134, meaning column-end value after reset or SWRESET.
REQ-002 SHALL have parameter DEF_YE, default 16'd239, meaning row-end value after reset or SWRESET.
REQ-003 SHALL have ports: clk input 1 system clock; rst input 1 asynchronous active-low reset.
REQ-004 SHALL have lcd_rst input 1 panel hardware reset, active-low, asynchronous to clk.
REQ-005 SHALL have lcd_cs, lcd_scl, lcd_sd, lcd_rs inputs 1 each: chip select (active-low), serial clock, serial data, data/command select (0=command), all asynchronous to clk.
REQ-006 SHALL have byte_valid output 1, byte_data output 8, byte_dc output 1: received-byte strobe, value and its lcd_rs level.
REQ-007 SHALL have pix_valid output 1, pix_x output 16, pix_y output 16, pix_data output 16: RGB565 pixel-write strobe, address and value.
REQ-008 SHALL have sleep, disp_on, inv_on outputs 1 each: panel state flags; unk_cmd output 1: pulse on an unsupported opcode.

Function
REQ-009 SHALL pass lcd_cs, lcd_scl, lcd_sd, lcd_rs, lcd_rst through 2-flop synchronizers; correct operation requires clk >= 4x scl frequency.
REQ-010 SHALL detect a scl rising edge as synchronized scl 0 in the previous cycle and 1 in the current cycle, counted only while synchronized cs is 0.
REQ-011 SHALL shift sd in MSB first on each counted edge; the 3-bit bit counter increments and wraps from 7 to 0.
REQ-012 SHALL sample rs on the 8th counted edge and pulse byte_valid for exactly 1 clk in the following cycle, with byte_data/byte_dc valid in that cycle.
REQ-013 SHALL clear the bit counter and discard partial bits when synchronized cs goes high; opcode context and window registers are retained across cs toggles.
REQ-014 SHALL, on a byte with dc=0, load the opcode, clear the argument counter and pixel-byte phase; bytes with dc=1 are arguments of the current opcode.
REQ-015 SHALL decode opcodes: 0x01 SWRESET, 0x10 SLPIN (sleep=1), 0x11 SLPOUT (sleep=0), 0x20 INVOFF, 0x21 INVON, 0x28 DISPOFF, 0x29 DISPON, 0x2A CASET, 0x2B RASET, 0x2C RAMWR, 0x00 NOP; flag updates take effect in the cycle after the opcode byte_valid.
REQ-016 SHALL pulse unk_cmd for 1 clk, in the cycle after the opcode byte_valid, for any other opcode, and ignore that opcode's data bytes.
REQ-017 SHALL, for CASET/RASET, collect 4 argument bytes big-endian as start[15:0], end[15:0] and update the xs/xe (ys/ye) window in the cycle after the 4th argument only; fewer than 4 arguments leave the window unchanged; arguments 5+ are ignored.
REQ-018 SHALL, on RAMWR opcode, load the pointer to (xs, ys) and pixel phase 0.
REQ-019 SHALL, during RAMWR, treat phase-0 data as pix_data[15:8] and phase-1 data as pix_data[7:0], pulse pix_valid for 1 clk in the cycle after the phase-1 byte_valid with the current pointer, and then advance the pointer.
REQ-020 SHALL advance the pointer as follows: if x==xe then x<=xs, and y<=(y==ye ? ys : y+1); else x<=x+1 with 16-bit wraparound; only equality is compared, so xs>xe wraps through 0xFFFF.
REQ-021 SHALL emit pixels regardless of sleep/disp_on; a new command byte mid-pixel discards the pending high byte.
REQ-022 SHALL make SWRESET restore all decoder state to its reset values (REQ-024) in the cycle after its byte_valid.
REQ-023 SHALL treat synchronized lcd_rst=0 as a synchronous reset to reset values, held while low; no bytes are received while it is low.

Reset
REQ-024 SHALL, on rst=0, asynchronously set: byte_valid, pix_valid, unk_cmd, disp_on, inv_on = 0; sleep = 1; byte_data, byte_dc, pix_x, pix_y, pix_data = 0; xs=0, xe=DEF_XE, ys=0, ye=DEF_YE; opcode = NOP; bit counter, argument counter and phase = 0.
REQ-025 SHALL resume reception on the first full byte after rst deasserts; a byte in flight during reset is lost.

Verification
REQ-026 SHALL pass: cs=0, rs=0, byte 0x11 -> one byte_valid with byte_data=0x11 and byte_dc=0, then sleep=0; after byte 0x29, disp_on=1.
REQ-027 SHALL pass: CASET args 00 02 00 03, RASET args 00 05 00 06, RAMWR, then 5 pixels 0xF800..0xF804 -> pix (2,5),(3,5),(2,6),(3,6),(2,5) with matching pix_data.
REQ-028 SHALL pass: 3 bits clocked, then cs high, then cs low and byte 0x21 -> only byte 0x21 is reported and inv_on=1.
REQ-029 SHALL pass: byte 0x55 with rs=0 -> unk_cmd pulses once; following data bytes cause no pix_valid and no flag change.
REQ-030 SHALL pass: lcd_rst pulsed low mid-RAMWR, then a data byte -> no pix_valid, and flags/window equal their reset values.
REQ-031 SHALL pass: CASET with 2 args then RAMWR -> window unchanged (xs=0, xe=134); 135 pixels wrap x to 0 and set y to 1.
